// File: rtl/conv_pool_writeback.sv
// conv_pool_writeback: requantize conv accumulators, 2x2/2 max-pool via a half-row line buffer, write pooled pixels out.
// Write lands 2 cycles after the closing pixel; no backpressure; define RELU_EN to force negative values to zero.
module conv_pool_writeback #(
   parameter int DATA_WIDTH          = 16,
   parameter int ACC_WIDTH           = 32,
   parameter int OUT_FEATURE_WIDTH_W = 24,
   parameter int OUT_FEATURE_WIDTH_H = 24,
   parameter int NUM_MAPS            = 2,
   parameter int FRAC_SHIFT          = 8,
   parameter int ADDR_WIDTH          = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [ACC_WIDTH-1:0]  in_data,
   output logic                  out_wren,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  pool_done
);
   localparam int W  = OUT_FEATURE_WIDTH_W;
   localparam int H  = OUT_FEATURE_WIDTH_H;
   localparam int HW = W / 2;
   localparam int HH = H / 2;
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam int RW = (H > 1) ? $clog2(H) : 1;
   localparam int MW = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
   localparam int LW = (HW > 1) ? $clog2(HW) : 1;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [MW-1:0] map_q, map_d;
   logic          last_col, last_row, last_map, accept;

   logic                         s1_vld_q, s1_last_q;
   logic signed [DATA_WIDTH-1:0] s1_dat_q, s1_dat_d;
   logic signed [ACC_WIDTH-1:0]  shifted;
   logic [CW-1:0]                s1_col_q;
   logic [RW-1:0]                s1_row_q;
   logic [MW-1:0]                s1_map_q;

   logic signed [DATA_WIDTH-1:0] pair_q, h, out_data_d;
   logic signed [DATA_WIDTH-1:0] line_buf_q [HW];
   logic [LW-1:0]                lb_idx;
   logic [ADDR_WIDTH-1:0]        addr_d, out_addr_q;
   logic [DATA_WIDTH-1:0]        out_data_q;
   logic                         out_wren_q, wr_last_q, pool_done_q;

   assign last_col = (col_q == CW'(W - 1));
   assign last_row = (row_q == RW'(H - 1));
   assign last_map = (map_q == MW'(NUM_MAPS - 1));
   assign accept   = in_valid & ~start & ~pool_done_q;

   always_comb begin
      col_d = col_q + 1'b1;
      row_d = row_q;
      map_d = map_q;
      if (last_col) begin
         col_d = '0;
         row_d = row_q + 1'b1;
         if (last_row) begin
            row_d = '0;
            map_d = last_map ? '0 : map_q + 1'b1;
         end
      end
   end

   // Saturate in the accumulator domain before narrowing so wrap-around can never leak through.
   always_comb begin
      shifted = $signed(in_data) >>> FRAC_SHIFT;
      if (shifted > SAT_MAX)
         s1_dat_d = SAT_MAX[DATA_WIDTH-1:0];
      else if (shifted < SAT_MIN)
         s1_dat_d = SAT_MIN[DATA_WIDTH-1:0];
      else
         s1_dat_d = shifted[DATA_WIDTH-1:0];
`ifdef RELU_EN
      if (s1_dat_d[DATA_WIDTH-1])
         s1_dat_d = '0;
`endif
   end

   always_comb begin
      lb_idx     = LW'(s1_col_q >> 1);
      h          = (s1_dat_q > pair_q) ? s1_dat_q : pair_q;
      out_data_d = (line_buf_q[lb_idx] > h) ? line_buf_q[lb_idx] : h;
      addr_d     = ADDR_WIDTH'(int'(s1_map_q) * (HW * HH) + int'(s1_row_q >> 1) * HW + int'(lb_idx));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_q       <= '0;
         row_q       <= '0;
         map_q       <= '0;
         s1_vld_q    <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_dat_q    <= '0;
         s1_col_q    <= '0;
         s1_row_q    <= '0;
         s1_map_q    <= '0;
         pair_q      <= '0;
         out_wren_q  <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         wr_last_q   <= 1'b0;
         pool_done_q <= 1'b0;
      end else if (start) begin
         // In-flight stage-1 entry is dropped here; out_addr/out_data keep their last values.
         col_q       <= '0;
         row_q       <= '0;
         map_q       <= '0;
         s1_vld_q    <= 1'b0;
         s1_last_q   <= 1'b0;
         out_wren_q  <= 1'b0;
         wr_last_q   <= 1'b0;
         pool_done_q <= 1'b0;
      end else begin
         s1_vld_q <= accept;
         if (accept) begin
            col_q     <= col_d;
            row_q     <= row_d;
            map_q     <= map_d;
            s1_dat_q  <= s1_dat_d;
            s1_col_q  <= col_q;
            s1_row_q  <= row_q;
            s1_map_q  <= map_q;
            s1_last_q <= last_col & last_row & last_map;
         end
         out_wren_q <= 1'b0;
         wr_last_q  <= 1'b0;
         if (s1_vld_q) begin
            if (!s1_col_q[0]) begin
               pair_q <= s1_dat_q;
            end else if (s1_row_q[0]) begin
               out_wren_q <= 1'b1;
               out_addr_q <= addr_d;
               out_data_q <= out_data_d;
               wr_last_q  <= s1_last_q;
            end
         end
         pool_done_q <= pool_done_q | wr_last_q;
      end
   end

   // Line buffer contents need no reset: every odd row reads only what the even row above just wrote.
   always_ff @(posedge clock) begin
      if (!start && s1_vld_q && s1_col_q[0] && !s1_row_q[0])
         line_buf_q[lb_idx] <= h;
   end

   assign out_wren  = out_wren_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign pool_done = pool_done_q;
endmodule

// File: tb/tb_conv_pool_writeback.sv
// Bench for conv_pool_writeback: two instances (1 map/no shift, 2 maps/shift 8) share one stimulus stream
// and are checked every cycle against a frame-level pooling model.
`timescale 1ns/1ps
module tb_conv_pool_writeback;
   localparam int W = 4;
   localparam int H = 4;
   localparam int NEVER = 1 << 30;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;

   logic        wren_a, done_a, wren_b, done_b;
   logic [9:0]  addr_a, addr_b;
   logic [15:0] data_a, data_b;

   conv_pool_writeback #(.OUT_FEATURE_WIDTH_W(W), .OUT_FEATURE_WIDTH_H(H), .NUM_MAPS(1), .FRAC_SHIFT(0)) u_a (
      .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .out_wren(wren_a), .out_addr(addr_a), .out_data(data_a), .pool_done(done_a));

   conv_pool_writeback #(.OUT_FEATURE_WIDTH_W(W), .OUT_FEATURE_WIDTH_H(H), .NUM_MAPS(2), .FRAC_SHIFT(8)) u_b (
      .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .out_wren(wren_b), .out_addr(addr_b), .out_data(data_b), .pool_done(done_b));

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   typedef struct { int due; int addr; int data; } exp_t;
   exp_t expq [2][$];
   int   grid [2][H][W];
   int   col [2], row [2], map [2];
   int   done_edge [2];
   int   last_addr [2], last_data [2];
   int   wr_cnt [2];
   int   edge_cnt = 0;

   function automatic int nm_of(input int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic int fs_of(input int d);
      return (d == 0) ? 0 : 8;
   endfunction

   function automatic int quant(input logic [31:0] raw, input int fs);
      longint v;
      v = longint'($signed(raw)) >>> fs;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
`ifdef RELU_EN
      if (v < 0) v = 0;
`endif
      return int'(v);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         expq[d].delete();
         col[d] = 0; row[d] = 0; map[d] = 0;
         done_edge[d] = NEVER;
         last_addr[d] = 0; last_data[d] = 0;
      end
   endtask

   // Reference: build each map frame, emit one expected write per completed 2x2 block.
   always @(posedge clock) begin : model
      int k, r, c, m;
      k = edge_cnt;
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            if (start) begin
               while (expq[d].size() > 0 && expq[d][$].due >= k) void'(expq[d].pop_back());
               col[d] = 0; row[d] = 0; map[d] = 0;
               done_edge[d] = NEVER;
            end else if (in_valid && !(done_edge[d] <= k - 1)) begin
               r = row[d]; c = col[d];
               grid[d][r][c] = quant(in_data, fs_of(d));
               if ((r % 2 == 1) && (c % 2 == 1)) begin
                  m = max2(max2(grid[d][r-1][c-1], grid[d][r-1][c]), max2(grid[d][r][c-1], grid[d][r][c]));
                  expq[d].push_back('{k + 1, map[d] * (W/2) * (H/2) + (r/2) * (W/2) + c/2, m});
                  if (map[d] == nm_of(d) - 1 && r == H - 1 && c == W - 1) done_edge[d] = k + 2;
               end
               col[d]++;
               if (col[d] == W) begin
                  col[d] = 0; row[d]++;
                  if (row[d] == H) begin
                     row[d] = 0; map[d]++;
                     if (map[d] == nm_of(d)) map[d] = 0;
                  end
               end
            end
         end
      end
      edge_cnt = k + 1;
   end

   always @(negedge clock) begin : monitor
      int   last;
      logic exp_w, w, dn;
      logic [9:0]  a;
      logic [15:0] dt;
      last = edge_cnt - 1;
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            exp_w = (expq[d].size() > 0 && expq[d][0].due == last);
            if (exp_w) begin
               last_addr[d] = expq[d][0].addr;
               last_data[d] = expq[d][0].data;
               void'(expq[d].pop_front());
            end
            w  = (d == 0) ? wren_a : wren_b;
            a  = (d == 0) ? addr_a : addr_b;
            dt = (d == 0) ? data_a : data_b;
            dn = (d == 0) ? done_a : done_b;
            if (w) wr_cnt[d]++;
            check_eq($sformatf("wren%0d@%0d", d, last), w, exp_w);
            check_eq($sformatf("addr%0d@%0d", d, last), a, last_addr[d][9:0]);
            check_eq($sformatf("data%0d@%0d", d, last), dt, last_data[d][15:0]);
            check_eq($sformatf("done%0d@%0d", d, last), dn, done_edge[d] <= last);
         end
      end
   end

   task automatic pulse_start(input logic with_valid, input logic [31:0] v);
      @(negedge clock);
      start = 1'b1; in_valid = with_valid; in_data = v;
      @(negedge clock);
      start = 1'b0; in_valid = 1'b0;
   endtask

   task automatic feed(input logic [31:0] v, input int gap);
      @(negedge clock);
      in_valid = 1'b1; in_data = v;
      repeat (gap) begin
         @(negedge clock);
         in_valid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      @(negedge clock);
      in_valid = 1'b0;
      repeat (n - 1) @(negedge clock);
   endtask

   task automatic feed_const(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) feed(v, 0);
      idle(5);
   endtask

   initial begin
      logic [31:0] v;
      model_reset();
      #1;
      check_eq("rst_wren_a", wren_a, 0);
      check_eq("rst_addr_a", addr_a, 0);
      check_eq("rst_data_a", data_a, 0);
      check_eq("rst_done_a", done_a, 0);
      check_eq("rst_done_b", done_b, 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Basic pooling, values 0..15.
      pulse_start(1'b0, '0);
      for (int i = 0; i < 16; i++) feed(i, 0);
      idle(5);
      check_eq("basic_done_a", done_a, 1);
      check_eq("basic_addr_a", addr_a, 3);
      check_eq("basic_data_a", data_a, 15);
      check_eq("basic_done_b", done_b, 0);

      // Saturation high then low.
      pulse_start(1'b0, '0);
      feed_const(32'h7FFF_FF00, 32);
      check_eq("sat_hi_a", data_a, 16'h7FFF);
      check_eq("sat_hi_b", data_b, 16'h7FFF);
      pulse_start(1'b0, '0);
      feed_const(32'h8000_0000, 32);
      check_eq("sat_lo_a", data_a, 16'h8000);
      check_eq("sat_lo_b", data_b, 16'h8000);

      // Negative values (ReLU build clamps them to zero).
      pulse_start(1'b0, '0);
      feed_const(32'hFFFF_FFFD, 32);
`ifdef RELU_EN
      check_eq("relu_a", data_a, 16'h0000);
      check_eq("relu_b", data_b, 16'h0000);
`else
      check_eq("relu_a", data_a, 16'hFFFD);
      check_eq("relu_b", data_b, 16'hFFFF);
`endif

      // Gapped input across two maps.
      pulse_start(1'b0, '0);
      wr_cnt[0] = 0; wr_cnt[1] = 0;
      for (int i = 0; i < 32; i++) begin
         v = $urandom;
         feed($signed(v) >>> 12, 1);
      end
      idle(5);
      check_eq("gap_writes_a", wr_cnt[0], 4);
      check_eq("gap_writes_b", wr_cnt[1], 8);
      check_eq("gap_last_addr_b", addr_b, 7);
      check_eq("gap_done_b", done_b, 1);

      // Restart mid-run with a dropped simultaneous sample.
      pulse_start(1'b0, '0);
      for (int i = 0; i < 10; i++) feed($urandom_range(0, 50000), 0);
      pulse_start(1'b1, 32'd999);
      #1 wr_cnt[0] = 0;
      for (int i = 0; i < 16; i++) feed(100 + i, 0);
      idle(5);
      check_eq("restart_writes_a", wr_cnt[0], 4);
      check_eq("restart_addr_a", addr_a, 3);
      check_eq("restart_data_a", data_a, 115);
      check_eq("restart_done_a", done_a, 1);

      // Randomized runs of varying length, gaps and magnitude.
      for (int run = 0; run < 8; run++) begin
         pulse_start($urandom_range(0, 1), $urandom);
         for (int i = 0; i < $urandom_range(8, 36); i++) begin
            v = $urandom;
            feed($signed(v) >>> $urandom_range(0, 24), $urandom_range(0, 2));
         end
         idle(4);
      end

      // Async reset pulse between edges while a write is on the outputs.
      pulse_start(1'b0, '0);
      for (int i = 0; i < 6; i++) feed(i, 0);
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      @(posedge clock);
      #2;
      check_eq("pre_rst_wren_a", wren_a, 1);
      check_eq("pre_rst_data_a", data_a, 5);
      reset = 1'b0;
      #0.5;
      check_eq("arst_wren_a", wren_a, 0);
      check_eq("arst_addr_a", addr_a, 0);
      check_eq("arst_data_a", data_a, 0);
      check_eq("arst_wren_b", wren_b, 0);
      check_eq("arst_data_b", data_b, 0);
      model_reset();
      #0.5;
      reset = 1'b1;

      // Recovery after reset.
      pulse_start(1'b0, '0);
      for (int i = 0; i < 16; i++) feed(i * 3, 0);
      idle(5);
      check_eq("post_rst_data_a", data_a, 45);
      check_eq("post_rst_done_a", done_a, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/conv_pool_writeback.md
Name: conv_pool_writeback

Overview:
- Downstream of the convolution control/multiply-accumulate stage.
- Consumes one accumulated convolution result per output pixel, in raster order and one map after another.
- Requantizes each result to DATA_WIDTH and applies 2x2 stride-2 max pooling through a half-row line buffer.
- Writes each pooled pixel into the output feature M9K and raises a done flag after the last map.

Parameters:
- DATA_WIDTH, 16: width of a stored feature value (signed).
- ACC_WIDTH, 32: width of an incoming accumulator result (signed).
- OUT_FEATURE_WIDTH_W, 24: conv output width in pixels; must be even.
- OUT_FEATURE_WIDTH_H, 24: conv output height in pixels; must be even.
- NUM_MAPS, 2: number of conv output maps received per run.
- FRAC_SHIFT, 8: arithmetic right shift applied for requantization.
- ADDR_WIDTH, 10: output memory address width; must cover NUM_MAPS*(W/2)*(H/2).

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: reset, asynchronous, active-low.
- start, input, 1: one-cycle pulse that clears counters, pipeline and done to begin a run.
- in_valid, input, 1: in_data carries one conv pixel this cycle.
- in_data, input, ACC_WIDTH: signed accumulator result.
- out_wren, output, 1: write strobe to the output feature memory.
- out_addr, output, ADDR_WIDTH: write address.
- out_data, output, DATA_WIDTH: pooled value.
- pool_done, output, 1: high after the last pooled write of the run.

Behaviour:
- Reset (reset low, asynchronous) sets all outputs to 0: out_wren=0, out_addr=0, out_data=0, pool_done=0. Counters, pipeline valid bits and line buffer valid are also cleared. Line buffer contents are don't-care.
- Counters:
  - col counts 0..W-1; it wraps to 0 and increments row.
  - row counts 0..H-1; it wraps to 0 and increments map.
  - map counts 0..NUM_MAPS-1.
  - Each in_valid with pool_done=0 advances col by one.
- Stage 1, registered, one cycle after in_valid:
  - q = in_data >>> FRAC_SHIFT.
  - If q > 2^(DATA_WIDTH-1)-1, clamp to that value.
  - If q < -2^(DATA_WIDTH-1), clamp to that value.
  - The position tags (col, row, map) are carried alongside q.
- Stage 2, registered, two cycles after in_valid:
  - Even col: hold q in the pair register.
  - Odd col: h = signed max(pair register, q).
  - Odd col, even row: write h to line_buf[col/2].
  - Odd col, odd row: out_data = signed max(line_buf[col/2], h) and out_wren=1 for one cycle.
  - In that write cycle, out_addr = map*(W/2)*(H/2) + (row/2)*(W/2) + col/2.
- Latency: out_wren goes high exactly 2 cycles after the in_valid of every odd-row/odd-col pixel. Back-to-back in_valid is supported at one pixel per clock. Gaps in in_valid are allowed; no state advances during a gap.
- pool_done:
  - Set in the cycle after the write of map NUM_MAPS-1, row H-1, col W-1.
  - Sticky until the next start or reset.
  - While pool_done=1, in_valid is ignored and no writes occur.
- start:
  - Clears counters, pipeline valid bits, pool_done and out_wren on the next edge.
  - start has priority over a simultaneous in_valid; that sample is dropped.
  - A start in mid-run abandons the partial run. In-flight pipeline entries are discarded and never written.
- Ties in max: equal values yield the same value; no preference is defined.
- out_addr and out_data hold their last written values while out_wren=0.

Optional Feature:
- RELU_EN defined: after saturation in stage 1, negative q is forced to 0, so every pooled output is >= 0.
- RELU_EN undefined: signed values pass through to pooling unchanged.
- Latency is identical in both builds.

Test Plan:
- Setup for all scenarios unless stated: W=4, H=4, NUM_MAPS=1, FRAC_SHIFT=0.
- Basic pooling:
  - Stimulus: pulse start, then feed 16 consecutive in_valid with values 0..15 in raster order.
  - Required: writes (addr,data) = (0,5), (1,7), (2,13), (3,15), each 2 cycles after the pixel 5, 7, 13 and 15 inputs.
  - Required: pool_done rises the cycle after the last write.
- Saturation:
  - Stimulus: FRAC_SHIFT=8, DATA_WIDTH=16; all pixels 0x7FFFFF00; then a second run with all pixels 0x80000000.
  - Required: every out_data = 0x7FFF in the first run and 0x8000 in the second.
- ReLU:
  - Stimulus: all 16 pixels = -3.
  - Required: with RELU_EN, out_data = 0 at all 4 addresses; without RELU_EN, out_data = -3.
- Gapped input and multi-map:
  - Stimulus: NUM_MAPS=2, in_valid asserted every other cycle, 32 pixels.
  - Required: exactly 8 writes at addresses 0..7; map-1 results land at addresses 4..7.
- Restart mid-run:
  - Stimulus: start asserted after 10 pixels, with in_valid high in the same cycle; then 16 new pixels with values 100..115.
  - Required: no write is produced from the first 10 pixels after the restart.
  - Required: writes are (0,105), (1,107), (2,113), (3,115).
- Async reset:
  - Stimulus: reset low for 1 ns between clock edges during a write cycle.
  - Required: out_wren, out_data, out_addr and pool_done all read 0 immediately, before the next clock edge.
